// File: rtl/hc595_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hc595_pkg : shared widths, FSM states and frame packing for the 595 chain
// Revision  : 1.0
// ----------------------------------------------------------------------------
package hc595_pkg;

  localparam int SEG_W     = 8;
  localparam int SEL_W     = 6;
  localparam int FRAME_W   = SEG_W + SEL_W;
  localparam int DIGIT_NUM = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Segment byte goes out first so it lands in the far chip of the cascade.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [SEG_W-1:0] seg,
                                                     input logic [SEL_W-1:0] sel);
    return {seg, sel};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_shift_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hc595_shift_ctrl : serializes one {seg, sel} frame into two cascaded 74HC595
// Revision         : 1.0
// ----------------------------------------------------------------------------
module hc595_shift_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int FRAME_W = 14
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] seg,
  input  logic [5:0] sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       frame_done
);
  import hc595_pkg::*;

  localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  logic in_ready_q, in_ready_d;
  logic ds_q, ds_d;
  logic shcp_q, shcp_d;
  logic stcp_q, stcp_d;
  logic oe_q, oe_d;
  logic done_q, done_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b1;
      ds_q       <= 1'b0;
      shcp_q     <= 1'b0;
      stcp_q     <= 1'b0;
      oe_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      ds_q       <= ds_d;
      shcp_q     <= shcp_d;
      stcp_q     <= stcp_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
    end
  end

  // div_cnt doubles as the stcp high-width timer while latching.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          shift_d   = FRAME_W'(pack_frame(seg, sel));
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt_q == LATCH_LAST) begin
          state_d   = IDLE;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so every pin comes from a flop.
  always_comb begin
    in_ready_d = (state_d == IDLE);
    shcp_d     = (state_d == SHIFT) && (div_cnt_d >= DIV_HALF);
    stcp_d     = (state_d == LATCH);
    done_d     = (state_q == LATCH) && (state_d == IDLE);
    ds_d       = (state_d == SHIFT) ? shift_d[FRAME_W-1] : ds_q;
    oe_d       = done_d ? 1'b0 : oe_q;
  end

  assign in_ready   = in_ready_q;
  assign ds         = ds_q;
  assign shcp       = shcp_q;
  assign stcp       = stcp_q;
  assign oe         = oe_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hc595_shift_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hc595_shift_ctrl : self-checking bench, CLK_DIV=2 and CLK_DIV=1 instances
// Revision            : 1.0
// ----------------------------------------------------------------------------
module tb_hc595_shift_ctrl;

  typedef struct {
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic [13:0] exp_bits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_a   [2];
  logic [5:0] sel_a   [2];
  logic       valid_a [2];
  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD      = (g == 0) ? 2 : 1;
    localparam int BIT_T   = 2 * CD;
    localparam int SHIFT_T = 14 * BIT_T;
    localparam int DONE_T  = SHIFT_T + CD;

    logic ds, shcp, stcp, oe, in_ready, frame_done;

    // Reference model: frames in flight with their transfer edge; every
    // expected pin value is derived from the elapsed cycles since transfer.
    logic [13:0] fq[$];
    int          tq[$];
    int          busy_end  = 0;
    logic        oe_m      = 1'b1;
    logic        prev_shcp = 1'b0;
    logic [13:0] cap       = '0;
    logic [13:0] last_bits = '0;
    int          done_cnt  = 0;
    int          last_done = 0;

    hc595_shift_ctrl #(.CLK_DIV(CD), .FRAME_W(14)) u_dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .seg       (seg_a[g]),
      .sel       (sel_a[g]),
      .in_valid  (valid_a[g]),
      .in_ready  (in_ready),
      .ds        (ds),
      .shcp      (shcp),
      .stcp      (stcp),
      .oe        (oe),
      .frame_done(frame_done)
    );

    always @(negedge clk) begin
      int          d;
      logic [13:0] f;
      logic        e_ready, e_shcp, e_stcp, e_done;
      if (rst) begin
        fq.delete();
        tq.delete();
        busy_end  = cyc + 1;
        oe_m      = 1'b1;
        prev_shcp = 1'b0;
        cap       = '0;
      end else begin
        e_ready = (cyc >= busy_end);
        e_shcp  = 1'b0;
        e_stcp  = 1'b0;
        e_done  = 1'b0;
        chk("in_ready", g, in_ready, e_ready);
        if (fq.size() > 0) begin
          d = cyc - tq[0];
          f = fq[0];
          if (d < SHIFT_T) begin
            e_shcp = ((d % BIT_T) >= CD);
            chk("ds_shift", g, ds, f[13 - d / BIT_T]);
          end else if (d < DONE_T) begin
            e_stcp = 1'b1;
            chk("ds_latch", g, ds, f[0]);
          end else begin
            e_done = 1'b1;
          end
        end
        if (shcp && !prev_shcp) cap = {cap[12:0], ds};
        prev_shcp = shcp;
        if (e_done) oe_m = 1'b0;
        chk("shcp", g, shcp, e_shcp);
        chk("stcp", g, stcp, e_stcp);
        chk("frame_done", g, frame_done, e_done);
        chk("oe", g, oe, oe_m);
        if (e_done) begin
          void'(fq.pop_front());
          void'(tq.pop_front());
          last_bits = cap;
          cap       = '0;
          done_cnt++;
          last_done = cyc;
        end
        if (valid_a[g] && e_ready) begin
          fq.push_back({seg_a[g], sel_a[g]});
          tq.push_back(cyc + 1);
          busy_end = cyc + 1 + DONE_T;
        end
      end
    end
  end

  function automatic int dcnt(input int g);
    return (g == 0) ? g_dut[0].done_cnt : g_dut[1].done_cnt;
  endfunction

  function automatic logic rdy(input int g);
    return (g == 0) ? g_dut[0].in_ready : g_dut[1].in_ready;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the transfer edge; t_xfer is that edge's cycle number.
  task automatic send(input int g, input logic [7:0] s, input logic [5:0] l,
                      input bit keep_valid, output int t_xfer);
    int k = 0;
    seg_a[g]   = s;
    sel_a[g]   = l;
    valid_a[g] = 1'b1;
    while (!rdy(g) && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) chk("send_timeout", g, 0, 1);
    t_xfer = cyc + 1;
    step(1);
    if (!keep_valid) valid_a[g] = 1'b0;
  endtask

  task automatic wait_frames(input int g, input int n, input int budget);
    int start = dcnt(g);
    int k     = 0;
    while (dcnt(g) < start + n && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_done", g, 32'(dcnt(g) >= start + n), 1);
  endtask

  initial begin
    vec_t tbl [5];
    int   t, t_first, n0;

    seg_a   = '{8'h00, 8'h00};
    sel_a   = '{6'h00, 6'h00};
    valid_a = '{1'b0, 1'b0};
    tbl[0] = '{8'hC0, 6'b111110, 14'b11000000_111110};
    tbl[1] = '{8'hF9, 6'b111101, 14'b11111001_111101};
    tbl[2] = '{8'hA4, 6'b111011, 14'b10100100_111011};
    tbl[3] = '{8'h00, 6'b011111, 14'b00000000_011111};
    tbl[4] = '{8'hFF, 6'b000000, 14'b11111111_000000};

    rst = 1'b1;
    step(3);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("idle_ds", 0, g_dut[0].ds, 0);
      chk("idle_oe", 0, g_dut[0].oe, 1);
      chk("idle_ready", 0, g_dut[0].in_ready, 1);
    end

    // Table frames; seg is scrambled mid-frame to prove capture isolation.
    for (int i = 0; i < 5; i++) begin
      send(0, tbl[i].seg, tbl[i].sel, 1'b0, t);
      step(5);
      seg_a[0] = 8'($urandom);
      wait_frames(0, 1, 100);
      chk("tbl_bits", 0, g_dut[0].last_bits, tbl[i].exp_bits);
      chk("tbl_done_latency", 0, g_dut[0].last_done - t, 58);
    end

    // Back-to-back with in_valid held high.
    n0 = dcnt(0);
    t_first = 0;
    for (int k = 0; k < 6; k++) begin
      send(0, 8'($urandom), 6'(~(6'b1 << k)), 1'b1, t);
      if (k == 0) t_first = t;
      step(20);
      seg_a[0] = 8'($urandom);
    end
    valid_a[0] = 1'b0;
    wait_frames(0, 6 - (dcnt(0) - n0), 120);
    chk("b2b_count", 0, dcnt(0) - n0, 6);
    chk("b2b_span", 0, t - t_first, 5 * 59);

    // in_valid pulses while busy must be ignored.
    n0 = dcnt(0);
    send(0, 8'h92, 6'b110111, 1'b0, t);
    step(9);
    seg_a[0] = 8'h11; valid_a[0] = 1'b1; step(1); valid_a[0] = 1'b0;
    step(19);
    seg_a[0] = 8'h22; valid_a[0] = 1'b1; step(1); valid_a[0] = 1'b0;
    wait_frames(0, 1, 100);
    step(80);
    chk("ignore_count", 0, dcnt(0) - n0, 1);
    chk("ignore_bits", 0, g_dut[0].last_bits, 14'b10010010_110111);

    // Reset during bit 7 of a frame.
    n0 = dcnt(0);
    send(0, 8'h5A, 6'b101111, 1'b0, t);
    step(28);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_shcp", 0, g_dut[0].shcp, 0);
    chk("rst_stcp", 0, g_dut[0].stcp, 0);
    chk("rst_oe", 0, g_dut[0].oe, 1);
    chk("rst_ready", 0, g_dut[0].in_ready, 1);
    step(80);
    chk("rst_no_frame", 0, dcnt(0) - n0, 0);

    // CLK_DIV=1 instance, all-ones frame.
    send(1, 8'hFF, 6'h3F, 1'b0, t);
    wait_frames(1, 1, 60);
    chk("div1_bits", 1, g_dut[1].last_bits, 14'h3FFF);
    chk("div1_done_latency", 1, g_dut[1].last_done - t, 29);

    // Random traffic on both instances against the model.
    for (int i = 0; i < 400; i++) begin
      for (int g = 0; g < 2; g++) begin
        valid_a[g] = ($urandom_range(0, 2) == 0);
        seg_a[g]   = 8'($urandom);
        sel_a[g]   = 6'($urandom);
      end
      step(1);
    end
    valid_a[0] = 1'b0;
    valid_a[1] = 1'b0;
    step(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/hc595_shift_ctrl.md
Name: hc595_shift_ctrl

Overview:
- Serializer stage for the two cascaded 74HC595 chips that drive the 6-digit 7-segment display.
- Consumes one 14-bit display frame per scan step (segment pattern seg[7:0] plus digit select sel[5:0]) from the dynamic-scan stage over a valid/ready handshake.
- Shifts the frame out on ds/shcp, then pulses stcp to latch the 595 outputs.
- Drives the board pins stcp, shcp, ds and oe directly.

Parameters:
- CLK_DIV, 2, shcp half-period in sys_clk cycles; also the stcp high width; legal range is 1 or more.
- FRAME_W, 14, bits per frame, equal to SEG_W + SEL_W; fixed for the two-chip chain.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous reset, active-high.
- seg  in  8  segment pattern, seg[7] = dp, active-low segments.
- sel  in  6  digit select, one-hot active-low.
- in_valid  in  1  frame on seg/sel is valid.
- in_ready  out  1  block can accept a frame (IDLE only).
- ds  out  1  serial data to the first 595 SER pin.
- shcp  out  1  shift clock to the 595s.
- stcp  out  1  storage latch clock to the 595s.
- oe  out  1  595 output enable, active-low.
- frame_done  out  1  one-cycle pulse after each latch completes.

Behaviour:
- All outputs are registered. Reset is synchronous: sys_rst high at a sys_clk edge forces the reset values on that edge.
- Reset values: in_ready=1, ds=0, shcp=0, stcp=0, oe=1 (outputs disabled), frame_done=0, state=IDLE.
- Frame packing: frame = {seg, sel}. The shift order is frame[13] first, down to frame[0] last.
- Transfer: the frame is accepted on the edge where in_valid and in_ready are both 1. seg and sel are captured into shift_reg on that edge, and in_ready drops to 0 on the same edge.
- States:
  - IDLE: in_ready=1, shcp=0, stcp=0. Goes to SHIFT on transfer.
  - SHIFT: phase counter div_cnt runs 0..2*CLK_DIV-1 and bit counter bit_cnt runs 0..FRAME_W-1.
    - ds = shift_reg MSB, stable for the whole bit.
    - shcp=0 while div_cnt < CLK_DIV, shcp=1 otherwise. The rising edge therefore falls mid-bit, CLK_DIV cycles after ds changes.
    - At div_cnt wrap, shift_reg shifts left by one and bit_cnt increments.
    - After the last bit wraps, go to LATCH.
  - LATCH: shcp=0, ds holds the last bit, stcp=1 for CLK_DIV cycles.
    - On exit, stcp=0, frame_done=1 for one cycle, oe=0 (and stays 0 until the next reset), in_ready=1.
    - Then return to IDLE.
- Timing: transfer on edge T; bit 0 on ds from T+1. Bit i shcp rises at T+1+i*2*CLK_DIV+CLK_DIV. stcp rises at T+1+FRAME_W*2*CLK_DIV. in_ready and frame_done go to 1 at T+1+FRAME_W*2*CLK_DIV+CLK_DIV.
- With defaults: 14 shcp rises at T+3, T+7, ..., T+55. stcp is high T+57..T+58. Ready/done at T+59. Frame period is 59 cycles; the next transfer is possible on the T+59 edge.
- Back-to-back: in_valid held high gives a transfer on the same edge in_ready is observed high. No idle bubble beyond that single ready cycle.
- in_valid while in_ready=0 is ignored. seg/sel changes after capture have no effect on the frame in flight.
- Reset mid-SHIFT or mid-LATCH:
  - Immediate return to reset values; stcp is never pulsed for a partial frame.
  - oe returns to 1 so the partial shift content is never displayed.
- Counters are sized to $clog2(2*CLK_DIV) and $clog2(FRAME_W) and must never exceed their terminal values.

Decomposition:
- Shared package hc595_pkg holds:
  - SEG_W=8, SEL_W=6, FRAME_W=SEG_W+SEL_W, and DIGIT_NUM=6.
  - State enum: IDLE, SHIFT, LATCH.
  - The frame-pack function {seg, sel}.
- No sub-module is needed. The div_cnt/bit_cnt pair stays inline; a separate clock-enable generator is not warranted.

Test Plan:
- Reset release, no valid: in_ready=1, oe=1, shcp/stcp/ds=0 held for 100 cycles; no shcp edges.
- seg=8'hC0, sel=6'b111110, one-cycle valid: ds sampled at the 14 shcp rises = 1,1,0,0,0,0,0,0,1,1,1,1,1,0. Exactly one stcp pulse, 2 cycles wide, rising 57 cycles after transfer. frame_done at +59; oe=0 afterwards.
- in_valid held high with 6 frames, sel rotating 111110..011111: 6 stcp pulses exactly 59 cycles apart; each frame's bits match its captured value. Changing seg mid-frame does not alter the bits.
- in_valid pulsed at cycles +10 and +30 during a shift: both ignored; exactly one frame emitted.
- sys_rst asserted at bit 7 of a frame: next edge has shcp=0, stcp=0, oe=1, in_ready=1; no stcp pulse occurs for that frame.
- CLK_DIV=1 build, frame 14'h3FFF: 14 shcp rises 2 cycles apart, ds=1 throughout, stcp high 1 cycle at +29, ready at +30.
